// File: rtl/fu_rr_arbiter.sv
// fu_rr_arbiter: round-robin sharing of one functional unit between NUM_REQ requesters
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_din_1/2       per-requester operands, slice i belongs to requester i
//   req_alu_sel       per-requester 4-bit opcode
//   req_v / req_r     request valid / accept (accept is one-hot or zero)
//   rsp_dout          shared result bus, valid for whichever rsp_v bit is set
//   rsp_v / rsp_r     result valid (one-hot or zero) / per-requester result ready
//   fu_*              interface to the single FU instance; feedback mode is never used
module fu_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din_2,
  input  logic [NUM_REQ*4-1:0]          req_alu_sel,
  input  logic [NUM_REQ-1:0]            req_v,
  output logic [NUM_REQ-1:0]            req_r,
  output logic [DATA_WIDTH-1:0]         rsp_dout,
  output logic [NUM_REQ-1:0]            rsp_v,
  input  logic [NUM_REQ-1:0]            rsp_r,
  output logic [DATA_WIDTH-1:0]         fu_din_1,
  output logic [DATA_WIDTH-1:0]         fu_din_2,
  output logic [3:0]                    fu_alu_sel,
  output logic                          fu_din_v,
  input  logic                          fu_din_r,
  input  logic [DATA_WIDTH-1:0]         fu_dout,
  input  logic                          fu_dout_v,
  output logic                          fu_dout_r,
  output logic                          fu_feedback,
  output logic [DATA_WIDTH-1:0]         fu_init_val,
  output logic [15:0]                   fu_delay_val
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e              state_q, state_d;
  logic [IW-1:0]       gnt_q, gnt_d, last_q, last_d, pick, idx;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                in_issue, in_wait, in_resp;
  // First requesting index after last_q, wrapping at NUM_REQ (which need not be a power of two)
  always_comb begin
    pick = gnt_q;
    idx  = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
      if (req_v[idx] && pick == gnt_q && !req_v[gnt_q]) pick = idx;
      else if (req_v[idx] && k == 0) pick = idx;
    end
    idx = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
      if (req_v[idx]) begin
        pick = idx;
        break;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    res_d   = res_q;
    case (state_q)
      IDLE:
        if (|req_v) begin
          gnt_d   = pick;
          state_d = ISSUE;
        end
      // Losing valid before acceptance abandons the grant without advancing the pointer
      ISSUE:
        if (!req_v[gnt_q]) state_d = IDLE;
        else if (fu_din_r) state_d = WAIT;
      WAIT:
        if (fu_dout_v) begin
          res_d   = fu_dout;
          state_d = RESP;
        end
      RESP:
        if (rsp_r[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      res_q   <= res_d;
    end
  end
  assign in_issue     = state_q == ISSUE;
  assign in_wait      = state_q == WAIT;
  assign in_resp      = state_q == RESP;
  assign gnt_oh       = NUM_REQ'(1) << gnt_q;
  assign fu_din_1     = req_din_1[gnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign fu_din_2     = req_din_2[gnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign fu_alu_sel   = req_alu_sel[gnt_q*4 +: 4];
  assign fu_din_v     = in_issue & req_v[gnt_q];
  assign fu_dout_r    = in_issue | in_wait;
  assign req_r        = (in_issue && fu_din_r && req_v[gnt_q]) ? gnt_oh : '0;
  assign rsp_v        = in_resp ? gnt_oh : '0;
  assign rsp_dout     = res_q;
  assign fu_feedback  = 1'b0;
  assign fu_init_val  = '0;
  assign fu_delay_val = '0;
endmodule

// File: tb/tb_fu_rr_arbiter.sv
// tb_fu_rr_arbiter: directed checks of grant order, handshakes, holds, reset and wrap-around results
module tb_fu_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] req_din_1 = '0;
  logic [N*W-1:0] req_din_2 = '0;
  logic [N*4-1:0] req_alu_sel = '0;
  logic [N-1:0]   req_v = '0;
  logic [N-1:0]   req_r;
  logic [W-1:0]   rsp_dout;
  logic [N-1:0]   rsp_v;
  logic [N-1:0]   rsp_r = '1;
  logic [W-1:0]   fu_din_1, fu_din_2, fu_init_val;
  logic [3:0]     fu_alu_sel;
  logic           fu_din_v, fu_dout_r, fu_feedback;
  logic           fu_din_r = 1'b1;
  logic [W-1:0]   fu_dout;
  logic           fu_dout_v;
  logic [15:0]    fu_delay_val;
  int             n_chk = 0;
  int             n_fail = 0;
  fu_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_din_1(req_din_1), .req_din_2(req_din_2), .req_alu_sel(req_alu_sel),
    .req_v(req_v), .req_r(req_r),
    .rsp_dout(rsp_dout), .rsp_v(rsp_v), .rsp_r(rsp_r),
    .fu_din_1(fu_din_1), .fu_din_2(fu_din_2), .fu_alu_sel(fu_alu_sel),
    .fu_din_v(fu_din_v), .fu_din_r(fu_din_r),
    .fu_dout(fu_dout), .fu_dout_v(fu_dout_v), .fu_dout_r(fu_dout_r),
    .fu_feedback(fu_feedback), .fu_init_val(fu_init_val), .fu_delay_val(fu_delay_val)
  );
  always #5 clk = ~clk;
  // One-cycle FU: 0 add, 1 multiply, 2 subtract, all truncated to W bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_dout_v <= 1'b0;
      fu_dout   <= '0;
    end else begin
      fu_dout_v <= fu_din_v & fu_din_r;
      fu_dout   <= fu_alu_sel == 4'd1 ? fu_din_1 * fu_din_2 :
                   fu_alu_sel == 4'd2 ? fu_din_1 - fu_din_2 : fu_din_1 + fu_din_2;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    req_din_1[i*W +: W] = a;
    req_din_2[i*W +: W] = b;
    req_alu_sel[i*4 +: 4] = s;
  endtask
  task automatic run_op(input int i, input logic [W-1:0] exp);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    req_v = oh;
    #1;
    chk("op_idle_req_r", req_r, 0);
    tick();
    chk("op_accept", req_r, oh);
    chk("op_fu_din_v", fu_din_v, 1);
    tick();
    req_v = '0;
    #1;
    chk("op_wait_fu_din_v", fu_din_v, 0);
    chk("op_wait_rsp_v", rsp_v, 0);
    tick();
    chk("op_rsp_v", rsp_v, oh);
    chk("op_rsp_dout", rsp_dout, exp);
    tick();
    chk("op_back_idle", rsp_v, 0);
  endtask
  logic [N-1:0] gexp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [W-1:0] dexp [5] = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd11};
  initial begin
    int g, r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_r", req_r, 0);
    chk("rst_rsp_v", rsp_v, 0);
    chk("rst_fu_din_v", fu_din_v, 0);
    chk("rst_fu_dout_r", fu_dout_r, 0);
    chk("rst_rsp_dout", rsp_dout, 0);
    rst_n = 1'b1;
    // T1: basic add with latency checks
    set_op(0, 3, 4, 0);
    run_op(0, 7);
    // T2: all requesting, fresh pointer, rotation 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 10 * (i + 1), i + 1, 0);
    g = 0;
    r = 0;
    req_v = '1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_r != 0) begin
        chk("t2_gnt", req_r, g < 5 ? gexp[g] : '0);
        g++;
      end
      if (rsp_v != 0) begin
        chk("t2_rsp_v", rsp_v, r < 5 ? gexp[r] : '0);
        chk("t2_rsp_dout", rsp_dout, r < 5 ? dexp[r] : '0);
        r++;
      end
      if (c == 19) req_v = '0;
      tick();
    end
    chk("t2_grant_count", g, 5);
    chk("t2_rsp_count", r, 5);
    // T3: requester 2 stalls its response for 5 cycles while requester 0 waits
    set_op(2, 100, 23, 0);
    req_v = 4'b0100;
    rsp_r = 4'b1011;
    tick();
    chk("t3_accept", req_r, 4'b0100);
    tick();
    req_v = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_rsp_v_hold", rsp_v, 4'b0100);
      chk("t3_rsp_dout_hold", rsp_dout, 123);
      chk("t3_no_req_r", req_r, 0);
      tick();
    end
    rsp_r = '1;
    tick();
    chk("t3_idle_rsp_v", rsp_v, 0);
    chk("t3_idle_req_r", req_r, 0);
    tick();
    chk("t3_next_accept", req_r, 4'b0001);
    tick();
    req_v = '0;
    tick();
    chk("t3_next_rsp_v", rsp_v, 4'b0001);
    chk("t3_next_rsp_dout", rsp_dout, 11);
    tick();
    // T4: FU not ready for 3 ISSUE cycles
    set_op(3, 7, 9, 0);
    req_v = 4'b1000;
    fu_din_r = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t4_fu_din_v_hold", fu_din_v, 1);
      chk("t4_req_r_low", req_r, 0);
      if (k < 2) tick();
    end
    fu_din_r = 1'b1;
    #1;
    chk("t4_accept", req_r, 4'b1000);
    tick();
    req_v = '0;
    tick();
    chk("t4_rsp_v", rsp_v, 4'b1000);
    chk("t4_rsp_dout", rsp_dout, 16);
    tick();
    // T5: reset while waiting on the FU
    set_op(0, 1, 2, 0);
    req_v = 4'b0001;
    tick();
    chk("t5_accept", req_r, 4'b0001);
    tick();
    chk("t5_wait_fu_dout_r", fu_dout_r, 1);
    rst_n = 1'b0;
    req_v = 4'b1010;
    #1;
    chk("t5_rst_req_r", req_r, 0);
    chk("t5_rst_rsp_v", rsp_v, 0);
    chk("t5_rst_fu_din_v", fu_din_v, 0);
    chk("t5_rst_fu_dout_r", fu_dout_r, 0);
    chk("t5_rst_rsp_dout", rsp_dout, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_idle_req_r", req_r, 0);
    tick();
    chk("t5_grant_1", req_r, 4'b0010);
    tick();
    req_v = '0;
    tick();
    chk("t5_rsp_v", rsp_v, 4'b0010);
    chk("t5_rsp_dout", rsp_dout, 22);
    tick();
    // T6: wrapping multiply and subtract
    set_op(2, 32'h0001_0000, 32'h0001_0000, 1);
    run_op(2, 32'h0000_0000);
    set_op(3, 0, 1, 2);
    run_op(3, 32'hFFFF_FFFF);
    // Abandoned grant: pointer stays at 3, so 0 still wins over 1
    set_op(0, 5, 5, 0);
    req_v = 4'b0001;
    fu_din_r = 1'b0;
    tick();
    chk("ab_fu_din_v", fu_din_v, 1);
    req_v = '0;
    #1;
    chk("ab_fu_din_v_drop", fu_din_v, 0);
    tick();
    fu_din_r = 1'b1;
    req_v = 4'b0011;
    tick();
    chk("ab_regrant_0", req_r, 4'b0001);
    tick();
    req_v = '0;
    tick();
    chk("ab_rsp_dout", rsp_dout, 10);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
